// File: rtl/sip_shift_accumulator_if.sv
// Beat/result channel between the SIP dot adder, the shift accumulator and the
// requantization stage. The master drives beats and consumes results.
interface sip_shift_accumulator_if #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 24,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 6
);
  logic                      i_valid;
  logic                      o_ready;
  logic signed [IN_W-1:0]    i_psum;
  logic        [SHIFT_W-1:0] i_shift;
  logic                      i_neg;
  logic                      i_first;
  logic                      i_last;
  logic                      o_valid;
  logic                      i_ready;
  logic signed [ACC_W-1:0]   o_acc;
  logic                      o_ovf;
  logic        [CNT_W-1:0]   o_beats;

  modport master (
    output i_valid, i_psum, i_shift, i_neg, i_first, i_last, i_ready,
    input  o_ready, o_valid, o_acc, o_ovf, o_beats
  );

  modport slave (
    input  i_valid, i_psum, i_shift, i_neg, i_first, i_last, i_ready,
    output o_ready, o_valid, o_acc, o_ovf, o_beats
  );
endinterface

// File: rtl/sip_shift_accumulator.sv
// Shifts each bit-plane partial sum by its plane weight, optionally negates it,
// and accumulates a group into one wide signed result with a valid/ready output.
//
// state  | meaning
// IDLE   | nothing accumulated, accepting beats
// ACC    | group in progress, accepting beats
// HOLD   | result presented; a beat is accepted only when downstream takes it
module sip_shift_accumulator #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 24,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  sip_shift_accumulator_if.slave         s_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_acc_out;
  logic                    r_ovf;
  logic [CNT_W-1:0]        r_beats;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_base_zero;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W:0]   w_term;
  logic signed [ACC_W:0]   w_base;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_illegal;
  logic                    w_ovf_beat;
  logic                    w_ovf_nxt;
  logic [CNT_W-1:0]        w_beats_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // o_ready depends only on state and downstream ready, never on i_valid
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    if (r_state == S_HOLD) w_ready = s_bus.i_ready;
    w_accept = s_bus.i_valid && w_ready;
    if (w_accept)                                  w_state_nxt = s_bus.i_last ? S_HOLD : S_ACC;
    else if (r_state == S_HOLD && s_bus.i_ready)   w_state_nxt = S_IDLE;
  end

  // Term and sum carry one guard bit so a wrapped add or negated minimum shows up as overflow
  assign w_ext       = {{(ACC_W-IN_W){s_bus.i_psum[IN_W-1]}}, s_bus.i_psum};
  assign w_shifted   = w_ext <<< s_bus.i_shift;
  assign w_term      = s_bus.i_neg ? -{w_shifted[ACC_W-1], w_shifted}
                                   :  {w_shifted[ACC_W-1], w_shifted};
  assign w_base_zero = (r_state != S_ACC) || s_bus.i_first;
  assign w_base      = w_base_zero ? '0 : {r_acc[ACC_W-1], r_acc};
  assign w_sum       = w_base + w_term;
  assign w_illegal   = s_bus.i_shift > SHIFT_W'(ACC_W - IN_W);
  assign w_ovf_beat  = (w_sum[ACC_W] ^ w_sum[ACC_W-1]) || w_illegal;
  assign w_ovf_nxt   = w_base_zero ? w_ovf_beat : (r_ovf | w_ovf_beat);
  assign w_beats_nxt = w_base_zero ? CNT_W'(1)
                                   : ((&r_beats) ? r_beats : r_beats + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_out <= '0;
      r_ovf     <= 1'b0;
      r_beats   <= '0;
    end else if (w_accept) begin
      r_acc   <= w_sum[ACC_W-1:0];
      r_ovf   <= w_ovf_nxt;
      r_beats <= w_beats_nxt;
      if (s_bus.i_last) r_acc_out <= w_sum[ACC_W-1:0];
    end
  end

  assign s_bus.o_ready = w_ready;
  assign s_bus.o_valid = (r_state == S_HOLD);
  assign s_bus.o_acc   = r_acc_out;
  assign s_bus.o_ovf   = r_ovf;
  assign s_bus.o_beats = r_beats;

endmodule
